// File: rtl/decode_in_queue_pkg.sv
// rtl/decode_in_queue_pkg.sv - shared entry type and default widths for the decode input queue
package decode_in_pkg_hdl;

    localparam int DECODE_IN_INSTR_W = 16;
    localparam int DECODE_IN_NPC_W   = 16;
    localparam int DECODE_IN_DEPTH   = 4;

    typedef struct packed {
        logic [DECODE_IN_INSTR_W-1:0] instr;
        logic [DECODE_IN_NPC_W-1:0]   npc;
    } decode_in_entry_t;

endpackage

// File: rtl/decode_in_queue_if.sv
// rtl/decode_in_queue_if.sv - fetch-to-decode handshake bundle for the decode input queue
interface decode_in_queue_if #(
    parameter int INSTR_W = decode_in_pkg_hdl::DECODE_IN_INSTR_W,
    parameter int NPC_W   = decode_in_pkg_hdl::DECODE_IN_NPC_W
);

    logic               wr_valid;
    logic               wr_ready;
    logic [INSTR_W-1:0] wr_instr;
    logic [NPC_W-1:0]   wr_npc;
    logic               rd_valid;
    logic               rd_ready;
    logic [INSTR_W-1:0] rd_instr;
    logic [NPC_W-1:0]   rd_npc;
    logic               enable_decode;

    // master: fetch producer plus decode consumer; slave: the queue itself
    modport master (
        output wr_valid, wr_instr, wr_npc, rd_ready,
        input  wr_ready, rd_valid, rd_instr, rd_npc, enable_decode
    );

    modport slave (
        input  wr_valid, wr_instr, wr_npc, rd_ready,
        output wr_ready, rd_valid, rd_instr, rd_npc, enable_decode
    );

endinterface

// File: rtl/decode_in_queue_ram.sv
// rtl/decode_in_queue_ram.sv - entry storage: one write port, asynchronous read, no reset
module decode_in_queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/decode_in_queue.sv
// rtl/decode_in_queue.sv - first-word fall-through fetch-to-decode queue with flush
// Optional empty-queue bypass enabled by defining DECODE_IN_QUEUE_BYPASS_EN.
module decode_in_queue #(
    parameter int INSTR_W  = decode_in_pkg_hdl::DECODE_IN_INSTR_W,
    parameter int NPC_W    = decode_in_pkg_hdl::DECODE_IN_NPC_W,
    parameter int DEPTH    = decode_in_pkg_hdl::DECODE_IN_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    decode_in_queue_if.slave q,
    output logic [CW-1:0] count,
    output logic          almost_full
);

    localparam int EW              = INSTR_W + NPC_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AF_LEVEL);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] ram_rdata;
    logic          stored_valid;
    logic          bypass;
    logic          push;
    logic          store;
    logic          drop_head;

    assign stored_valid = (count != '0);

`ifdef DECODE_IN_QUEUE_BYPASS_EN
    assign bypass = reset && !stored_valid && q.wr_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign q.wr_ready      = reset && (count < FULL);
    assign q.rd_valid      = (reset && stored_valid) || bypass;
    assign q.enable_decode = q.rd_valid && q.rd_ready;
    assign almost_full     = reset && (count >= AF);

    always_comb begin
        q.rd_instr = '0;
        q.rd_npc   = '0;
        if (reset && stored_valid) begin
            {q.rd_instr, q.rd_npc} = ram_rdata;
        end
`ifdef DECODE_IN_QUEUE_BYPASS_EN
        else if (bypass) begin
            q.rd_instr = q.wr_instr;
            q.rd_npc   = q.wr_npc;
        end
`endif
    end

    // A bypassed entry that decode takes immediately never touches storage
    assign push      = q.wr_valid && q.wr_ready;
    assign store     = push && !(bypass && q.rd_ready);
    assign drop_head = q.enable_decode && stored_valid;

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (drop_head) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({store, drop_head})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    decode_in_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clock (clock),
        .we    (store && reset && !flush),
        .waddr (wr_ptr),
        .wdata ({q.wr_instr, q.wr_npc}),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_decode_in_queue.sv
// tb/tb_decode_in_queue.sv - table, directed and random checks of decode_in_queue against a queue model
module tb_decode_in_queue;
    import decode_in_pkg_hdl::*;

    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = 3;
`ifdef DECODE_IN_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;
    logic          almost_full;

    decode_in_queue_if #(.INSTR_W(16), .NPC_W(16)) bus ();

    decode_in_queue #(
        .INSTR_W (16),
        .NPC_W   (16),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AFL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .q           (bus),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    decode_in_entry_t mq[$];

    typedef struct {
        logic        wv;
        logic        rr;
        logic [15:0] wi;
        logic [15:0] wn;
        int          e_cnt;
        logic        e_wrr;
        logic        e_rv;
        logic        e_af;
        logic [15:0] e_i;
        logic [15:0] e_n;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic rr, input logic fl,
                         input logic [15:0] wi, input logic [15:0] wn);
        bus.wr_valid = wv;
        bus.rd_ready = rr;
        bus.wr_instr = wi;
        bus.wr_npc   = wn;
        flush        = fl;
    endtask

    // Expected outputs follow directly from the queue contents and current inputs
    task automatic check_model(input string tag);
        int               n;
        bit               byp;
        bit               rv;
        decode_in_entry_t head;
        n    = mq.size();
        byp  = BYP && reset && (n == 0) && bus.wr_valid && !flush;
        rv   = (reset && n > 0) || byp;
        head = '0;
        if (reset && n > 0) head = mq[0];
        else if (byp)       head = '{instr: bus.wr_instr, npc: bus.wr_npc};
        chk({tag, ".count"},    32'(count),             32'(n));
        chk({tag, ".wr_ready"}, 32'(bus.wr_ready),      32'(reset && n < DEPTH));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid),      32'(rv));
        chk({tag, ".rd_data"},  {bus.rd_instr, bus.rd_npc}, 32'(head));
        chk({tag, ".enable"},   32'(bus.enable_decode), 32'(rv && bus.rd_ready));
        chk({tag, ".af"},       32'(almost_full),       32'(reset && n >= AFL));
    endtask

    task automatic tick();
        int               n;
        bit               byp;
        decode_in_entry_t e;
        @(posedge clock);
        n = mq.size();
        e = '{instr: bus.wr_instr, npc: bus.wr_npc};
        if (!reset || flush) begin
            mq.delete();
        end else begin
            byp = BYP && (n == 0) && bus.wr_valid;
            if (byp) begin
                if (!bus.rd_ready) mq.push_back(e);
            end else begin
                if (bus.rd_ready && n > 0) void'(mq.pop_front());
                if (bus.wr_valid && n < DEPTH) mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic step(input logic wv, input logic rr, input logic fl,
                        input logic [15:0] wi, input logic [15:0] wn, input string tag);
        drive(wv, rr, fl, wi, wn);
        @(negedge clock);
        check_model(tag);
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h3001, 0, 1'b1, BYP,  1'b0,
                   BYP ? 16'h1234 : 16'h0, BYP ? 16'h3001 : 16'h0};
        tbl[1] = '{1'b1, 1'b0, 16'h1235, 16'h3002, 1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h3001};
        tbl[2] = '{1'b1, 1'b0, 16'h1236, 16'h3003, 2, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h3001};
        tbl[3] = '{1'b1, 1'b0, 16'h1237, 16'h3004, 3, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h3001};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h3001};
        tbl[5] = '{1'b1, 1'b1, 16'hbeef, 16'hbeef, 4, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h3001};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 3, 1'b1, 1'b1, 1'b1, 16'h1235, 16'h3002};
        tbl[7] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 2, 1'b1, 1'b1, 1'b0, 16'h1236, 16'h3003};
        tbl[8] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1, 1'b1, 1'b1, 1'b0, 16'h1237, 16'h3004};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};

        // Reset held for two edges with traffic offered
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222);
        tick();
        tick();
        @(negedge clock);
        chk("reset.count",    32'(count),             32'd0);
        chk("reset.wr_ready", 32'(bus.wr_ready),      32'd0);
        chk("reset.rd_valid", 32'(bus.rd_valid),      32'd0);
        chk("reset.enable",   32'(bus.enable_decode), 32'd0);
        chk("reset.af",       32'(almost_full),       32'd0);
        chk("reset.rd_data",  {bus.rd_instr, bus.rd_npc}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        chk("release.wr_ready", 32'(bus.wr_ready), 32'd1);
        tick();

        // Fill to full, refuse push at full with concurrent pop, drain in order
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wv, tbl[i].rr, 1'b0, tbl[i].wi, tbl[i].wn);
            @(negedge clock);
            chk($sformatf("tbl%0d.count", i),    32'(count),        32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.wr_ready", i), 32'(bus.wr_ready), 32'(tbl[i].e_wrr));
            chk($sformatf("tbl%0d.rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d.af", i),       32'(almost_full),  32'(tbl[i].e_af));
            chk($sformatf("tbl%0d.rd_data", i),  {bus.rd_instr, bus.rd_npc}, {tbl[i].e_i, tbl[i].e_n});
            chk($sformatf("tbl%0d.enable", i),   32'(bus.enable_decode), 32'(tbl[i].e_rv && tbl[i].rr));
            tick();
        end

        // Steady push+pop at count 2 across pointer wrap
        step(1'b1, 1'b0, 1'b0, 16'ha000, 16'hb000, "wrap.fill0");
        step(1'b1, 1'b0, 1'b0, 16'ha001, 16'hb001, "wrap.fill1");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'(16'ha002 + i), 16'(16'hb002 + i));
            @(negedge clock);
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'd2);
            chk($sformatf("wrap%0d.head", i), {bus.rd_instr, bus.rd_npc},
                {16'(16'ha000 + i), 16'(16'hb000 + i)});
            check_model($sformatf("wrap%0d", i));
            tick();
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, "wrap.drain0");
        step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, "wrap.drain1");

        // Flush at count 3 with push and pop offered
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'(16'hc000 + i), 16'(16'hd000 + i), "flush.fill");
        end
        step(1'b1, 1'b1, 1'b1, 16'h7777, 16'h7777, "flush.cycle");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        chk("flush.count",    32'(count),        32'd0);
        chk("flush.rd_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, "flush.after");

        // Empty-queue push with decode ready
        drive(1'b1, 1'b1, 1'b0, 16'h5020, 16'h6020);
        @(negedge clock);
        chk("byp.same_cycle", 32'(bus.enable_decode), 32'(BYP));
        check_model("byp.c0");
        tick();
        drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        chk("byp.next_cycle", 32'(bus.enable_decode), 32'(!BYP));
        chk("byp.next_instr", 32'(bus.rd_instr), BYP ? 32'h0 : 32'h5020);
        check_model("byp.c1");
        tick();
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, "byp.c2");

        // Reset mid-operation discards entries
        step(1'b1, 1'b0, 1'b0, 16'he000, 16'hf000, "mrst.fill0");
        step(1'b1, 1'b0, 1'b0, 16'he001, 16'hf001, "mrst.fill1");
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, "mrst.assert");
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        chk("mrst.count",    32'(count),        32'd0);
        chk("mrst.rd_valid", 32'(bus.rd_valid), 32'd0);
        tick();

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 79) != 0);
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 31) == 0),
                 16'($urandom), 16'($urandom), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
